// File: rtl/sdram_ctrl_mb.sv
// SDRAM controller: power-up init, periodic refresh, single-beat read/write.
// Define OPEN_PAGE_EN to keep rows open per bank; default closes every row with auto-precharge.
module sdram_ctrl_mb #(
  parameter int BANK_NUM = 4,
  parameter int ROW_W    = 13,
  parameter int COL_W    = 9,
  parameter int DATA_W   = 16,
  parameter int CAS_LAT  = 3,
  parameter int T_RCD    = 3,
  parameter int T_RP     = 3,
  parameter int T_RC     = 9,
  parameter int T_WR     = 2,
  parameter int T_REFI   = 780,
  parameter int INIT_CYC = 20000,
  parameter int BANK_W   = $clog2(BANK_NUM)
) (
  input  logic              CLK,
  input  logic              NRST,
  input  logic              REQ,
  input  logic              WE_IN,
  input  logic [BANK_W-1:0] BDR_IN,
  input  logic [ROW_W-1:0]  ROW_IN,
  input  logic [COL_W-1:0]  COL_IN,
  input  logic [DATA_W-1:0] DIN,
  output logic              ACK,
  output logic              RDY,
  output logic [DATA_W-1:0] DOUT,
  output logic              INIT_DONE,
  output logic              CKE,
  output logic              CS,
  output logic              RAS,
  output logic              CAS,
  output logic              WE_OUT,
  output logic [BANK_W-1:0] BDR_OUT,
  output logic [ROW_W-1:0]  ADR_OUT,
  inout  wire  [DATA_W-1:0] DQ
);
  localparam int TMR_W = $clog2(INIT_CYC + T_RC + T_RCD + T_RP + T_WR + CAS_LAT + 2);
  localparam int RFC_W = $clog2(T_REFI + 1);

  // {CS,RAS,CAS,WE}
  localparam logic [3:0] C_NOP = 4'b0111, C_ACT = 4'b0011, C_RD  = 4'b0101, C_WR = 4'b0100;
  localparam logic [3:0] C_PRE = 4'b0010, C_REF = 4'b0001, C_MRS = 4'b0000, C_DESEL = 4'b1111;

  // timer reloads hold (wait cycles - 1): next command lands exactly T cycles later
  localparam logic [TMR_W-1:0] W_INIT = TMR_W'(INIT_CYC - 1);
  localparam logic [TMR_W-1:0] W_RP   = TMR_W'(T_RP - 1);
  localparam logic [TMR_W-1:0] W_RC   = TMR_W'(T_RC - 1);
  localparam logic [TMR_W-1:0] W_RCD  = TMR_W'(T_RCD - 1);
  localparam logic [TMR_W-1:0] W_MRS  = TMR_W'(1);
`ifdef OPEN_PAGE_EN
  localparam logic [TMR_W-1:0] W_WR = TMR_W'(T_WR - 1);
  localparam logic [TMR_W-1:0] W_RD = TMR_W'(CAS_LAT);
  localparam logic             AP   = 1'b0;
`else
  localparam logic [TMR_W-1:0] W_WR = TMR_W'(T_WR + T_RP - 1);
  localparam logic [TMR_W-1:0] W_RD = TMR_W'(CAS_LAT + T_RP - 1);
  localparam logic             AP   = 1'b1;
`endif
  localparam logic [ROW_W-1:0] MRS_VAL = ROW_W'((1 << 9) | (CAS_LAT << 4));
  localparam logic [RFC_W-1:0] RFC_END = RFC_W'(T_REFI - 1);

  typedef enum logic [3:0] {
    INIT_WAIT, INIT_PALL, INIT_REF1, INIT_REF2, INIT_MRS,
    IDLE, REF_PALL, REFRESH, ACTIVATE, RW, PRECHARGE
  } state_t;

  state_t              state, state_n;
  logic [TMR_W-1:0]    tmr, tmr_n;
  logic [3:0]          cmd_n;
  logic [BANK_W-1:0]   bdr_n;
  logic [ROW_W-1:0]    adr_n;
  logic                ack_n, rd_n, wr_n, done_n, ref_clr, go_act, go_rw;
  logic                ref_pend;
  logic [RFC_W-1:0]    rfc;
  logic [CAS_LAT:0]    rd_vld_pipe;
  logic                dq_oe;
  logic [DATA_W-1:0]   dq_out;

  logic                lat_we;
  logic [BANK_W-1:0]   lat_bank;
  logic [ROW_W-1:0]    lat_row;
  logic [COL_W-1:0]    lat_col;
  logic [DATA_W-1:0]   lat_din;

  // in IDLE the request is issued in its acceptance cycle, before the latch holds it
  logic                in_idle, cur_we;
  logic [BANK_W-1:0]   cur_bank;
  logic [ROW_W-1:0]    cur_row, rw_adr;
  logic [COL_W-1:0]    cur_col;
  logic [DATA_W-1:0]   cur_din;
  logic [3:0]          rw_cmd;
  logic [TMR_W-1:0]    rw_tmr;

  assign in_idle  = (state == IDLE);
  assign cur_we   = in_idle ? WE_IN  : lat_we;
  assign cur_bank = in_idle ? BDR_IN : lat_bank;
  assign cur_row  = in_idle ? ROW_IN : lat_row;
  assign cur_col  = in_idle ? COL_IN : lat_col;
  assign cur_din  = in_idle ? DIN    : lat_din;
  assign rw_cmd   = cur_we ? C_WR : C_RD;
  assign rw_tmr   = cur_we ? W_WR : W_RD;

  always_comb begin
    rw_adr              = '0;
    rw_adr[COL_W-1:0]   = cur_col;
    rw_adr[10]          = AP;
  end

`ifdef OPEN_PAGE_EN
  logic [BANK_NUM-1:0]            row_open;
  logic [BANK_NUM-1:0][ROW_W-1:0] row_tab;
  logic                           page_hit, page_miss;

  assign page_hit  = row_open[BDR_IN] && (row_tab[BDR_IN] == ROW_IN);
  assign page_miss = row_open[BDR_IN] && !page_hit;

  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      row_open <= '0;
      row_tab  <= '0;
    end else if (cmd_n == C_ACT) begin
      row_open[bdr_n] <= 1'b1;
      row_tab[bdr_n]  <= adr_n;
    end else if (cmd_n == C_PRE) begin
      if (adr_n[10]) row_open <= '0;
      else           row_open[bdr_n] <= 1'b0;
    end
  end
`endif

  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) state <= INIT_WAIT;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    tmr_n   = (tmr == '0) ? tmr : tmr - 1'b1;
    cmd_n   = C_NOP;
    bdr_n   = '0;
    adr_n   = '0;
    ack_n   = 1'b0;
    rd_n    = 1'b0;
    wr_n    = 1'b0;
    ref_clr = 1'b0;
    go_act  = 1'b0;
    go_rw   = 1'b0;
    done_n  = INIT_DONE;
    unique case (state)
      INIT_WAIT: if (!CKE) tmr_n = W_INIT;
                 else if (tmr == '0) begin
                   state_n = INIT_PALL; cmd_n = C_PRE; adr_n[10] = 1'b1; tmr_n = W_RP;
                 end
      INIT_PALL: if (tmr == '0) begin state_n = INIT_REF1; cmd_n = C_REF; tmr_n = W_RC; end
      INIT_REF1: if (tmr == '0) begin state_n = INIT_REF2; cmd_n = C_REF; tmr_n = W_RC; end
      INIT_REF2: if (tmr == '0) begin
                   state_n = INIT_MRS; cmd_n = C_MRS; adr_n = MRS_VAL; tmr_n = W_MRS;
                 end
      INIT_MRS:  if (tmr == '0) begin state_n = IDLE; done_n = 1'b1; end
      IDLE: begin
        if (ref_pend) begin
          state_n = REF_PALL; cmd_n = C_PRE; adr_n[10] = 1'b1; tmr_n = W_RP;
        end else if (REQ) begin
          ack_n = 1'b1;
`ifdef OPEN_PAGE_EN
          if (page_hit) go_rw = 1'b1;
          else if (page_miss) begin
            state_n = PRECHARGE; cmd_n = C_PRE; bdr_n = BDR_IN; tmr_n = W_RP;
          end else go_act = 1'b1;
`else
          go_act = 1'b1;
`endif
        end
      end
      REF_PALL:  if (tmr == '0) begin
                   state_n = REFRESH; cmd_n = C_REF; tmr_n = W_RC; ref_clr = 1'b1;
                 end
      REFRESH:   if (tmr == '0) state_n = IDLE;
      PRECHARGE: if (tmr == '0) go_act = 1'b1;
      ACTIVATE:  if (tmr == '0) go_rw = 1'b1;
      RW:        if (tmr == '0) state_n = IDLE;
      default:   state_n = INIT_WAIT;
    endcase
    if (go_act) begin
      state_n = ACTIVATE; cmd_n = C_ACT; bdr_n = cur_bank; adr_n = cur_row; tmr_n = W_RCD;
    end
    if (go_rw) begin
      state_n = RW; cmd_n = rw_cmd; bdr_n = cur_bank; adr_n = rw_adr; tmr_n = rw_tmr;
      wr_n = cur_we; rd_n = !cur_we;
    end
  end

  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      tmr         <= '0;
      CKE         <= 1'b0;
      {CS, RAS, CAS, WE_OUT} <= C_DESEL;
      BDR_OUT     <= '0;
      ADR_OUT     <= '0;
      ACK         <= 1'b0;
      RDY         <= 1'b0;
      DOUT        <= '0;
      INIT_DONE   <= 1'b0;
      dq_oe       <= 1'b0;
      dq_out      <= '0;
      rd_vld_pipe <= '0;
      rfc         <= '0;
      ref_pend    <= 1'b0;
      lat_we      <= 1'b0;
      lat_bank    <= '0;
      lat_row     <= '0;
      lat_col     <= '0;
      lat_din     <= '0;
    end else begin
      tmr       <= tmr_n;
      CKE       <= 1'b1;
      {CS, RAS, CAS, WE_OUT} <= cmd_n;
      BDR_OUT   <= bdr_n;
      ADR_OUT   <= adr_n;
      ACK       <= ack_n;
      INIT_DONE <= done_n;
      dq_oe     <= wr_n;
      if (wr_n) dq_out <= cur_din;
      // read data is on DQ in the CAS_LAT-th cycle after READ; capture one edge later
      rd_vld_pipe <= {rd_vld_pipe[CAS_LAT-1:0], rd_n};
      RDY         <= rd_vld_pipe[CAS_LAT];
      if (rd_vld_pipe[CAS_LAT]) DOUT <= DQ;
      if (ack_n) begin
        lat_we   <= WE_IN;
        lat_bank <= BDR_IN;
        lat_row  <= ROW_IN;
        lat_col  <= COL_IN;
        lat_din  <= DIN;
      end
      if (INIT_DONE) rfc <= (rfc == RFC_END) ? '0 : rfc + 1'b1;
      if (INIT_DONE && rfc == RFC_END) ref_pend <= 1'b1;
      else if (ref_clr)                ref_pend <= 1'b0;
    end
  end

  assign DQ = dq_oe ? dq_out : 'z;

endmodule

// File: tb/tb_sdram_ctrl_mb.sv
// Directed bench for sdram_ctrl_mb: init timing, write/read round trip, refresh priority, mid-write reset.
module tb_sdram_ctrl_mb;
  logic        CLK, NRST, REQ, WE_IN;
  logic [1:0]  BDR_IN;
  logic [12:0] ROW_IN;
  logic [8:0]  COL_IN;
  logic [15:0] DIN;
  logic        ACK, RDY, INIT_DONE, CKE, CS, RAS, CAS, WE_OUT;
  logic [15:0] DOUT;
  logic [1:0]  BDR_OUT;
  logic [12:0] ADR_OUT;
  wire  [15:0] DQ;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  sdram_ctrl_mb #(.INIT_CYC(20), .T_REFI(120)) dut (
    .CLK(CLK), .NRST(NRST), .REQ(REQ), .WE_IN(WE_IN), .BDR_IN(BDR_IN),
    .ROW_IN(ROW_IN), .COL_IN(COL_IN), .DIN(DIN), .ACK(ACK), .RDY(RDY),
    .DOUT(DOUT), .INIT_DONE(INIT_DONE), .CKE(CKE), .CS(CS), .RAS(RAS),
    .CAS(CAS), .WE_OUT(WE_OUT), .BDR_OUT(BDR_OUT), .ADR_OUT(ADR_OUT), .DQ(DQ)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // minimal SDRAM: stores writes, returns reads CAS latency 3 after the command edge
  logic [15:0] mem [0:2047];
  logic [15:0] mdl_dq;
  logic [2:0]  mdl_pipe;
  logic        probe;
  wire  [3:0]  cmd = {CS, RAS, CAS, WE_OUT};

  always @(posedge CLK or negedge NRST) begin
    if (!NRST) mdl_pipe <= 3'b000;
    else begin
      if (cmd == 4'b0100) mem[{BDR_OUT, ADR_OUT[8:0]}] <= DQ;
      if (cmd == 4'b0101) mdl_dq <= mem[{BDR_OUT, ADR_OUT[8:0]}];
      mdl_pipe <= {mdl_pipe[1:0], cmd == 4'b0101};
    end
  end

  // probe drives a known pattern so a DUT that fails to release DQ shows up as contention
  assign DQ = mdl_pipe[2] ? mdl_dq : (probe ? 16'h3C3C : 16'hzzzz);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK); #1; cyc++;
  endtask

  task automatic tick_to(input int n);
    while (cyc < n) tick();
  endtask

  // PALL @21, REF @24 and @33, MRS @42, INIT_DONE @44 with INIT_CYC=20, T_RP=3, T_RC=9
  task automatic check_init();
    logic [7:0]  e_ctl;
    logic [14:0] e_adr;
    for (int c = 1; c <= 44; c++) begin
      tick();
      e_ctl = 8'hB8;
      e_adr = 15'h0000;
      case (c)
        21: begin e_ctl = 8'h90; e_adr = 15'h0400; end
        24, 33: e_ctl = 8'h88;
        42: begin e_ctl = 8'h80; e_adr = 15'h0230; end
        44: e_ctl = 8'hB9;
        default: ;
      endcase
      chk("init_ctl", {CKE, CS, RAS, CAS, WE_OUT, ACK, RDY, INIT_DONE}, e_ctl);
      chk("init_adr", {BDR_OUT, ADR_OUT}, e_adr);
    end
  endtask

  initial begin
    NRST = 1'b0; REQ = 1'b0; WE_IN = 1'b0; BDR_IN = '0; ROW_IN = '0; COL_IN = '0; DIN = '0;
    probe = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_ctl", {CKE, CS, RAS, CAS, WE_OUT, ACK, RDY, INIT_DONE}, 8'h78);
    chk("rst_adr", {BDR_OUT, ADR_OUT}, 15'h0000);
    chk("rst_dout", DOUT, 16'h0000);
    #3 NRST = 1'b1;
    cyc = 0;
    check_init();

    // write bank 1 row 0x55 col 0x12
    REQ = 1'b1; WE_IN = 1'b1; BDR_IN = 2'd1; ROW_IN = 13'h0055; COL_IN = 9'h012; DIN = 16'hA5A5;
    tick();
    chk("wr_ack", ACK, 1'b1);
    chk("wr_act", {cmd, BDR_OUT, ADR_OUT}, {4'b0011, 2'd1, 13'h0055});
    REQ = 1'b0; DIN = 16'h0000;
    tick();
    chk("ack_pulse", ACK, 1'b0);
    tick_to(48);
    chk("wr_cmd", {cmd, BDR_OUT, ADR_OUT}, {4'b0100, 2'd1, 13'h0412});
    chk("wr_dq", DQ, 16'hA5A5);
    tick();
    probe = 1'b1; #1;
    chk("wr_dq_release", DQ, 16'h3C3C);
    probe = 1'b0;

    // read back, requested while the write is still draining
    REQ = 1'b1; WE_IN = 1'b0;
    for (int c = 50; c <= 53; c++) begin
      tick();
      chk("holdoff_ack", ACK, 1'b0);
    end
    tick();
    chk("rd_ack", ACK, 1'b1);
    chk("rd_act", {cmd, BDR_OUT, ADR_OUT}, {4'b0011, 2'd1, 13'h0055});
    REQ = 1'b0;
    tick_to(57);
    chk("rd_cmd", {cmd, BDR_OUT, ADR_OUT}, {4'b0101, 2'd1, 13'h0412});
    tick_to(60);
    chk("rdy_early", RDY, 1'b0);
    tick();
    chk("rdy_pulse", RDY, 1'b1);
    chk("rd_data", DOUT, 16'hA5A5);
    tick();
    chk("rdy_low", RDY, 1'b0);
    chk("dout_hold", DOUT, 16'hA5A5);

    // refresh pending from edge 164 wins over a request raised in the same cycle
    tick_to(164);
    REQ = 1'b1; WE_IN = 1'b0; BDR_IN = 2'd0; ROW_IN = 13'h0005; COL_IN = 9'h020;
    tick();
    chk("ref_pall", {cmd, BDR_OUT, ADR_OUT}, {4'b0010, 2'd0, 13'h0400});
    chk("ref_noack", ACK, 1'b0);
    tick_to(168);
    chk("ref_cmd", cmd, 4'b0001);
    tick_to(177);
    chk("ref_trc_noack", ACK, 1'b0);
    tick();
    chk("ref_then_ack", ACK, 1'b1);
    chk("ref_then_act", {cmd, BDR_OUT, ADR_OUT}, {4'b0011, 2'd0, 13'h0005});
    REQ = 1'b0;
    tick_to(181);
    chk("rd2_cmd", {cmd, BDR_OUT, ADR_OUT}, {4'b0101, 2'd0, 13'h0420});
    tick_to(185);
    chk("rd2_rdy", RDY, 1'b1);

    // write with extreme row/col, then reset inside the write recovery window
    tick_to(190);
    REQ = 1'b1; WE_IN = 1'b1; BDR_IN = 2'd3; ROW_IN = 13'h1FFF; COL_IN = 9'h1FF; DIN = 16'h5A5A;
    tick();
    chk("wr3_act", {ACK, cmd, BDR_OUT, ADR_OUT}, {1'b1, 4'b0011, 2'd3, 13'h1FFF});
    REQ = 1'b0;
    tick_to(194);
    chk("wr3_cmd", {cmd, BDR_OUT, ADR_OUT}, {4'b0100, 2'd3, 13'h05FF});
    chk("wr3_dq", DQ, 16'h5A5A);
    tick();
    NRST = 1'b0;
    #1;
    chk("mid_rst_ctl", {CKE, CS, RAS, CAS, WE_OUT, ACK, RDY, INIT_DONE}, 8'h78);
    chk("mid_rst_adr", {BDR_OUT, ADR_OUT}, 15'h0000);
    chk("mid_rst_dout", DOUT, 16'h0000);
    probe = 1'b1; #1;
    chk("mid_rst_dq", DQ, 16'h3C3C);
    probe = 1'b0;
    #1 NRST = 1'b1;
    cyc = 0;
    check_init();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/sdram_ctrl_mb.md
SDRAM_CTRL_MB -- requirements
Module: sdram_ctrl_mb

Interface
REQ-001 Parameters (name, default, meaning): BANK_NUM 4 banks; ROW_W 13 row address bits (>=11); COL_W 9 column bits (<=10); DATA_W 16 DQ width; CAS_LAT 3 cycles (2 or 3); T_RCD 3 ACTIVE->READ/WRITE; T_RP 3 PRECHARGE->next; T_RC 9 REFRESH->next; T_WR 2 last write->PRECHARGE; T_REFI 780 cycles between refreshes; INIT_CYC 20000 power-up wait; BANK_W = clog2(BANK_NUM).
REQ-002 Ports (name direction width meaning): CLK in 1 clock; NRST in 1 asynchronous active-low reset; REQ in 1 request valid; WE_IN in 1 1=write 0=read; BDR_IN in BANK_W bank; ROW_IN in ROW_W row; COL_IN in COL_W column; DIN in DATA_W write data; ACK out 1 request accepted pulse; RDY out 1 read data valid pulse; DOUT out DATA_W read data; INIT_DONE out 1 init complete; CKE, CS, RAS, CAS, WE_OUT out 1 SDRAM command (CS/RAS/CAS/WE_OUT active low); BDR_OUT out BANK_W; ADR_OUT out ROW_W; DQ inout DATA_W.
REQ-003 The block SHALL use one clock CLK and an asynchronous active-low reset NRST.

Function
REQ-004 All outputs SHALL be registered; commands SHALL be issued one per cycle, NOP (CS=0, RAS=CAS=WE_OUT=1) whenever no other command.
REQ-005 States: INIT_WAIT, INIT_PALL, INIT_REF1, INIT_REF2, INIT_MRS, IDLE, REF_PALL, REFRESH, ACTIVATE, RW, PRECHARGE; every command state SHALL be followed by NOP cycles until its timing parameter expires.
REQ-006 Init: INIT_CYC NOPs, PRECHARGE ALL (ADR_OUT[10]=1), two REFRESH each followed by T_RC, MODE REGISTER SET with BDR_OUT=0, ADR_OUT = burst length 1, sequential, CAS_LAT in [6:4], write burst single (bit 9=1), other bits 0; INIT_DONE SHALL rise 2 cycles after MRS and stay high.
REQ-007 A refresh counter SHALL count from INIT_DONE and set refresh_pending at T_REFI-1, then reload; pending SHALL be cleared when REFRESH issues.
REQ-008 In IDLE, refresh_pending SHALL take priority over REQ; refresh SHALL precharge all open banks (REF_PALL, T_RP) before REFRESH (T_RC).
REQ-009 REQ SHALL be sampled only in IDLE with INIT_DONE=1 and no refresh pending; on acceptance ACK SHALL pulse one cycle and WE_IN/BDR_IN/ROW_IN/COL_IN/DIN SHALL be latched; REQ outside these conditions SHALL be held off (no ACK).
REQ-010 READ/WRITE SHALL drive BDR_OUT=bank, ADR_OUT[COL_W-1:0]=column, ADR_OUT[10] per REQ-017/018, unused ADR_OUT bits 0.
REQ-011 Write: DQ SHALL be driven with latched DIN only in the WRITE command cycle, high-Z otherwise; the bank SHALL NOT be precharged before T_WR elapses.
REQ-012 Read: DOUT SHALL capture DQ and RDY SHALL pulse one cycle at exactly CAS_LAT+1 clocks after the READ command cycle; DOUT SHALL hold until next read.
REQ-013 Minimum ACK-to-ACK spacing on back-to-back requests SHALL cover all open timing; a new READ SHALL NOT issue before the prior RDY pulse.
REQ-014 ADR_OUT and BDR_OUT SHALL be 0 (not high-Z) during NOP.

Reset
REQ-015 NRST low SHALL immediately force: state INIT_WAIT, CKE=0, CS=RAS=CAS=WE_OUT=1, ADR_OUT=0, BDR_OUT=0, ACK=RDY=INIT_DONE=0, DOUT=0, DQ high-Z, all counters and open-row table cleared.
REQ-016 Reset mid-operation SHALL abandon any transfer without ACK/RDY and restart the full init sequence; CKE SHALL go to 1 on the first clock after NRST release.

Configuration
REQ-017 With OPEN_PAGE_EN defined: a per-bank open flag and row register SHALL be kept; hit (same bank, same row) SHALL skip ACTIVATE; miss on open bank SHALL PRECHARGE (ADR_OUT[10]=0) then ACTIVATE; READ/WRITE use ADR_OUT[10]=0.
REQ-018 Without OPEN_PAGE_EN: every access SHALL be ACTIVATE then READ/WRITE with auto-precharge (ADR_OUT[10]=1), followed by T_RP (plus T_WR for writes) before IDLE; no row table exists.

Verification
REQ-019 Reset release -> INIT_DONE=1 after INIT_CYC + T_RP + 2*T_RC + 3 cycles; MRS ADR_OUT=13'h0230 with CAS_LAT=3.
REQ-020 Write bank 1 row 0x0055 col 0x12 data 0xA5A5, then read same -> RDY pulse 4 cycles after READ, DOUT=0xA5A5.
REQ-021 OPEN_PAGE_EN: two reads bank 2 row 7 -> single ACTIVATE; third read bank 2 row 8 -> PRECHARGE bank 2 then ACTIVATE row 8.
REQ-022 REQ held high across refresh_pending -> REF_PALL, REFRESH issued first, ACK after T_RC, REFRESH interval <= T_REFI + worst-case access length.
REQ-023 NRST pulsed low during write T_WR wait -> outputs at reset values same cycle, no ACK/RDY, init sequence repeats.
